// File: rtl/multdiv_arb_pkg.sv
// Shared types and constants for the multdiv request arbiter.
// The top module's optional WAIT watchdog is enabled by MULTDIV_ARB_TIMEOUT_EN.
package multdiv_arb_pkg;

  localparam int DATA_W = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant.
// The pointer names the favoured requester and moves past the one just served.
module rr_arbiter_2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req_valid,
  input  logic       advance,
  input  logic       served,
  output logic [1:0] grant,
  output logic       ptr
);

  logic ptr_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= 1'b0;
    end else if (advance) begin
      ptr_q <= ~served;
    end
  end

  // The favoured side wins a tie; a lone request always wins.
  assign grant[0] = req_valid[0] & (~ptr_q | ~req_valid[1]);
  assign grant[1] = req_valid[1] & ( ptr_q | ~req_valid[0]);
  assign ptr      = ptr_q;

endmodule

// File: rtl/multdiv_arbiter.sv
// Two-client round-robin arbiter/sequencer in front of one multdiv unit.
// Optional WAIT watchdog: define MULTDIV_ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module multdiv_arbiter
  import multdiv_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rq0_valid,
  output logic              rq0_ready,
  input  logic              rq0_op,
  input  logic [DATA_W-1:0] rq0_a,
  input  logic [DATA_W-1:0] rq0_b,
  input  logic              rq1_valid,
  output logic              rq1_ready,
  input  logic              rq1_op,
  input  logic [DATA_W-1:0] rq1_a,
  input  logic [DATA_W-1:0] rq1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_result,
  output logic              rsp0_exception,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_result,
  output logic              rsp1_exception,
  output logic [DATA_W-1:0] data_operandA,
  output logic [DATA_W-1:0] data_operandB,
  output logic              ctrl_MULT,
  output logic              ctrl_DIV,
  input  logic [DATA_W-1:0] data_result,
  input  logic              data_exception,
  input  logic              data_resultRDY,
  output arb_state_t        dbg_state,
  output logic              dbg_ptr
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. rqN_ready is combinational from rqN_valid (IDLE only); once
  // rspN_valid rises, it and its data hold until rspN_ready completes it.

  arb_state_t        state_q, state_d;
  logic [1:0]        grant;
  logic              accept, rdy_take, resp_done;
  logic              gnt_id_q, op_q, exc_q;
  logic [DATA_W-1:0] a_q, b_q, result_q;

`ifdef MULTDIV_ARB_TIMEOUT_EN
  localparam int TW = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wait_cnt_q;
  logic          timeout_hit;
`endif

  rr_arbiter_2 u_rr (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid ({rq1_valid, rq0_valid}),
    .advance   (resp_done),
    .served    (gnt_id_q),
    .grant     (grant),
    .ptr       (dbg_ptr)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    rdy_take  = 1'b0;
    resp_done = 1'b0;
`ifdef MULTDIV_ARB_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rq0_valid || rq1_valid) begin
          accept  = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      // RDY is not looked at here so a stale RDY from the last op is ignored.
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (data_resultRDY) begin
          rdy_take = 1'b1;
          state_d  = ST_RESP;
        end
`ifdef MULTDIV_ARB_TIMEOUT_EN
        else if (wait_cnt_q == TIMEOUT_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_RESP;
        end
`endif
      end
      ST_RESP: begin
        if (gnt_id_q ? rsp1_ready : rsp0_ready) begin
          resp_done = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt_id_q <= 1'b0;
      op_q     <= OP_MULT;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      if (accept) begin
        gnt_id_q <= grant[1];
        op_q     <= grant[1] ? rq1_op : rq0_op;
        a_q      <= grant[1] ? rq1_a  : rq0_a;
        b_q      <= grant[1] ? rq1_b  : rq0_b;
      end
      if (rdy_take) begin
        result_q <= data_result;
        exc_q    <= data_exception;
      end
`ifdef MULTDIV_ARB_TIMEOUT_EN
      else if (timeout_hit) begin
        result_q <= '0;
        exc_q    <= 1'b1;
      end
`endif
    end
  end

`ifdef MULTDIV_ARB_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_ISSUE) begin
      wait_cnt_q <= '0;
    end else if (state_q == ST_WAIT) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end
`endif

  assign rq0_ready      = accept & grant[0];
  assign rq1_ready      = accept & grant[1];
  assign ctrl_MULT      = (state_q == ST_ISSUE) && (op_q == OP_MULT);
  assign ctrl_DIV       = (state_q == ST_ISSUE) && (op_q == OP_DIV);
  assign data_operandA  = a_q;
  assign data_operandB  = b_q;
  assign rsp0_valid     = (state_q == ST_RESP) && !gnt_id_q;
  assign rsp1_valid     = (state_q == ST_RESP) &&  gnt_id_q;
  assign rsp0_result    = result_q;
  assign rsp1_result    = result_q;
  assign rsp0_exception = exc_q;
  assign rsp1_exception = exc_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_multdiv_arbiter.sv
// Directed bench for multdiv_arbiter; multdiv responses are driven by hand.
// Inputs change on the falling edge, outputs are checked 1 ns later.
module tb_multdiv_arbiter;
  import multdiv_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        rq0_valid, rq0_ready, rq0_op;
  logic [31:0] rq0_a, rq0_b;
  logic        rq1_valid, rq1_ready, rq1_op;
  logic [31:0] rq1_a, rq1_b;
  logic        rsp0_valid, rsp0_ready, rsp0_exception;
  logic [31:0] rsp0_result;
  logic        rsp1_valid, rsp1_ready, rsp1_exception;
  logic [31:0] rsp1_result;
  logic [31:0] data_operandA, data_operandB, data_result;
  logic        ctrl_MULT, ctrl_DIV, data_exception, data_resultRDY;
  arb_state_t  dbg_state;
  logic        dbg_ptr;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  multdiv_arbiter #(.TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset_n(reset_n),
    .rq0_valid(rq0_valid), .rq0_ready(rq0_ready), .rq0_op(rq0_op), .rq0_a(rq0_a), .rq0_b(rq0_b),
    .rq1_valid(rq1_valid), .rq1_ready(rq1_ready), .rq1_op(rq1_op), .rq1_a(rq1_a), .rq1_b(rq1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result),
    .rsp0_exception(rsp0_exception),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result),
    .rsp1_exception(rsp1_exception),
    .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  // Entered at an IDLE falling edge with requester 'who' driving its request.
  // Walks ISSUE/WAIT/RESP, supplying the multdiv answer after 'lat' extra WAIT cycles.
  task automatic serve(input int who, input logic op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input logic exc, input int lat, input int hold,
                       input bit stale);
    chk("accept_ready", 32'(who ? rq1_ready : rq0_ready), 32'd1);
    chk("other_ready_idle", 32'(who ? rq0_ready : rq1_ready), 32'd0);
    step();
    if (who == 0) rq0_valid = 1'b0; else rq1_valid = 1'b0;
    if (stale) begin
      data_result    = 32'h0bad_0bad;
      data_resultRDY = 1'b1;
    end
    chk("issue_state", 32'(dbg_state), 32'(ST_ISSUE));
    chk("issue_mult", 32'(ctrl_MULT), 32'(op == OP_MULT));
    chk("issue_div", 32'(ctrl_DIV), 32'(op == OP_DIV));
    chk("issue_opa", data_operandA, a);
    chk("issue_opb", data_operandB, b);
    chk("issue_rq0_ready", 32'(rq0_ready), 32'd0);
    chk("issue_rq1_ready", 32'(rq1_ready), 32'd0);
    step();
    data_resultRDY = 1'b0;
    chk("wait_state", 32'(dbg_state), 32'(ST_WAIT));
    chk("wait_pulse_gone", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    for (int i = 0; i < lat; i++) begin
      step();
      chk("wait_hold_state", 32'(dbg_state), 32'(ST_WAIT));
      chk("wait_hold_opa", data_operandA, a);
    end
    data_result    = res;
    data_exception = exc;
    data_resultRDY = 1'b1;
    if (who == 0) rsp0_ready = (hold == 0); else rsp1_ready = (hold == 0);
    step();
    data_resultRDY = 1'b0;
    data_result    = 32'hdead_beef;
    data_exception = ~exc;
    chk("resp_state", 32'(dbg_state), 32'(ST_RESP));
    chk("resp_valid", 32'(who ? rsp1_valid : rsp0_valid), 32'd1);
    chk("resp_other_valid", 32'(who ? rsp0_valid : rsp1_valid), 32'd0);
    chk("resp_result", who ? rsp1_result : rsp0_result, res);
    chk("resp_exception", 32'(who ? rsp1_exception : rsp0_exception), 32'(exc));
    for (int i = 1; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(who ? rsp1_valid : rsp0_valid), 32'd1);
      chk("hold_result", who ? rsp1_result : rsp0_result, res);
      chk("hold_exception", 32'(who ? rsp1_exception : rsp0_exception), 32'(exc));
      chk("hold_no_issue", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
      chk("hold_rq0_ready", 32'(rq0_ready), 32'd0);
      chk("hold_rq1_ready", 32'(rq1_ready), 32'd0);
    end
    if (who == 0) rsp0_ready = 1'b1; else rsp1_ready = 1'b1;
    step();
    chk("done_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("done_valid", 32'(who ? rsp1_valid : rsp0_valid), 32'd0);
    chk("done_ptr", 32'(dbg_ptr), 32'(who == 0));
  endtask

  initial begin
    reset_n = 1'b0;
    rq0_valid = 1'b0; rq0_op = OP_MULT; rq0_a = '0; rq0_b = '0;
    rq1_valid = 1'b0; rq1_op = OP_MULT; rq1_a = '0; rq1_b = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    data_result = '0; data_exception = 1'b0; data_resultRDY = 1'b0;
    step();
    step();
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("rst_ptr", 32'(dbg_ptr), 32'd0);
    chk("rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    chk("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    chk("rst_rsp_data", rsp0_result | rsp1_result, 32'd0);
    chk("rst_rsp_exc", 32'({rsp0_exception, rsp1_exception}), 32'd0);
    chk("rst_operands", data_operandA | data_operandB, 32'd0);
    reset_n = 1'b1;
    step();

    // rq0 MULT 3 x 7
    rq0_valid = 1'b1; rq0_op = OP_MULT; rq0_a = 32'd3; rq0_b = 32'd7;
    #1;
    serve(0, OP_MULT, 32'd3, 32'd7, 32'd21, 1'b0, 2, 0, 1'b0);

    // Both valid with pointer at 1: rq1 DIV 3/0 wins, stale RDY during ISSUE
    rq0_valid = 1'b1; rq0_op = OP_MULT; rq0_a = 32'd5; rq0_b = 32'd5;
    rq1_valid = 1'b1; rq1_op = OP_DIV;  rq1_a = 32'd3; rq1_b = 32'd0;
    #1;
    serve(1, OP_DIV, 32'd3, 32'd0, 32'd0, 1'b1, 1, 0, 1'b1);

    // rq0 waits its turn; rq1 requests again while rq0's response is held
    rq1_valid = 1'b1; rq1_op = OP_DIV; rq1_a = 32'd100; rq1_b = 32'd7;
    #1;
    serve(0, OP_MULT, 32'd5, 32'd5, 32'd25, 1'b0, 0, 5, 1'b0);
    serve(1, OP_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 3, 0, 1'b0);

    // Move pointer to 1, then reset during WAIT of an rq1 op
    rq0_valid = 1'b1; rq0_op = OP_MULT; rq0_a = 32'd12; rq0_b = 32'd12;
    #1;
    serve(0, OP_MULT, 32'd12, 32'd12, 32'd144, 1'b0, 4, 0, 1'b0);
    rq1_valid = 1'b1; rq1_op = OP_DIV; rq1_a = 32'd50; rq1_b = 32'd5;
    #1;
    chk("pre_rst_rq1_ready", 32'(rq1_ready), 32'd1);
    step();
    rq1_valid = 1'b0;
    step();
    chk("pre_rst_wait", 32'(dbg_state), 32'(ST_WAIT));
    reset_n = 1'b0;
    data_result = 32'd10; data_resultRDY = 1'b1;
    #1;
    chk("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    chk("mid_rst_ptr", 32'(dbg_ptr), 32'd0);
    chk("mid_rst_ctrl", 32'({ctrl_MULT, ctrl_DIV}), 32'd0);
    chk("mid_rst_operands", data_operandA | data_operandB, 32'd0);
    chk("mid_rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    step();
    data_resultRDY = 1'b0;
    reset_n = 1'b1;
    step();
    chk("post_rst_idle", 32'(dbg_state), 32'(ST_IDLE));
    chk("post_rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);

    // Both valid from reset: rq0 first, then rq1
    rq0_valid = 1'b1; rq0_op = OP_MULT; rq0_a = 32'd6; rq0_b = 32'd7;
    rq1_valid = 1'b1; rq1_op = OP_DIV;  rq1_a = 32'd8; rq1_b = 32'd2;
    #1;
    serve(0, OP_MULT, 32'd6, 32'd7, 32'd42, 1'b0, 1, 0, 1'b0);
    serve(1, OP_DIV, 32'd8, 32'd2, 32'd4, 1'b0, 0, 0, 1'b0);

`ifdef MULTDIV_ARB_TIMEOUT_EN
    // Watchdog: RDY never arrives, 16 WAIT cycles then forced RESP
    rq0_valid = 1'b1; rq0_op = OP_MULT; rq0_a = 32'd9; rq0_b = 32'd9;
    #1;
    chk("to_accept", 32'(rq0_ready), 32'd1);
    step();
    rq0_valid = 1'b0;
    step();
    for (int i = 0; i < 15; i++) step();
    chk("to_wait16", 32'(dbg_state), 32'(ST_WAIT));
    step();
    chk("to_resp_state", 32'(dbg_state), 32'(ST_RESP));
    chk("to_resp_valid", 32'(rsp0_valid), 32'd1);
    chk("to_resp_result", rsp0_result, 32'd0);
    chk("to_resp_exc", 32'(rsp0_exception), 32'd1);
    step();
    chk("to_done", 32'(dbg_state), 32'(ST_IDLE));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
